// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encoding,
// opcodes and datapath mux encodings.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_we;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational decode of the sequencer state into the datapath control word.
module mips_mc_outdec
  import mips_mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_rd    = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_we     = mem_ready;
        ctrl.pc_we     = mem_ready;
      end
      // Branch target is formed here while the opcode is still being decoded
      ST_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
      ST_MEMADR, ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        ctrl.mem_rd = 1'b1;
        ctrl.iord   = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_wr     = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      ST_MEMWB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_ADDIWB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.pc_we      = zero;
        ctrl.instr_done = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_we      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control sequencer: state register, next-state logic,
// reset gating of write strobes and the retired-instruction counter.
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op_c,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_we,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl;
  logic             illegal;

  mips_mc_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  assign illegal = (state_q == ST_DECODE) && !op_is_legal(op_c);

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op_c)
          OP_RTYPE:     state_d = ST_EXEC;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        if (op_c == OP_LW)      state_d = ST_MEMRD;
        else if (op_c == OP_SW) state_d = ST_MEMWR;
        else                    state_d = ST_FETCH;
      end
      ST_MEMRD:  state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:  state_d = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ADDIEX: state_d = ST_ADDIWB;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(ctrl.instr_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are masked by rst_n directly so they drop the instant reset asserts
  assign pc_we      = ctrl.pc_we      & rst_n;
  assign ir_we      = ctrl.ir_we      & rst_n;
  assign reg_we     = ctrl.reg_we     & rst_n;
  assign mem_wr     = ctrl.mem_wr     & rst_n;
  assign instr_done = ctrl.instr_done & rst_n;
  assign illegal_op = illegal         & rst_n;

  assign iord       = ctrl.iord;
  assign mem_rd     = ctrl.mem_rd;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: instruction-level reference model
// expands each instruction into expected per-cycle control words.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic       pc_we;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_we;
    logic       alu_src_a;
    logic [1:0] src_b;
    logic [1:0] aop;
    logic [1:0] psrc;
    logic       illegal;
    logic       done;
  } ctl_t;

  typedef struct {
    logic        mr;
    logic        z;
    logic [5:0]  op;
    ctl_t        exp;
    logic [15:0] cnt;
  } vec_t;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op_c;
  logic       zero;
  logic       mem_ready;

  logic        a_pc_we, a_iord, a_mem_rd, a_mem_wr, a_ir_we, a_reg_dst;
  logic        a_mem_to_reg, a_reg_we, a_alu_src_a, a_illegal_op, a_instr_done;
  logic [1:0]  a_alu_src_b, a_alu_op, a_pc_src;
  logic [15:0] a_cnt;
  logic        b_pc_we, b_iord, b_mem_rd, b_mem_wr, b_ir_we, b_reg_dst;
  logic        b_mem_to_reg, b_reg_we, b_alu_src_a, b_illegal_op, b_instr_done;
  logic [1:0]  b_alu_src_b, b_alu_op, b_pc_src;
  logic [3:0]  b_cnt;
  ctl_t        act16, act4;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.CNT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .op_c(op_c), .zero(zero), .mem_ready(mem_ready),
    .pc_we(a_pc_we), .iord(a_iord), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr),
    .ir_we(a_ir_we), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .reg_we(a_reg_we), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
    .alu_op(a_alu_op), .pc_src(a_pc_src), .illegal_op(a_illegal_op),
    .instr_done(a_instr_done), .instr_cnt(a_cnt)
  );

  mips_mc_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .op_c(op_c), .zero(zero), .mem_ready(mem_ready),
    .pc_we(b_pc_we), .iord(b_iord), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
    .ir_we(b_ir_we), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .reg_we(b_reg_we), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .alu_op(b_alu_op), .pc_src(b_pc_src), .illegal_op(b_illegal_op),
    .instr_done(b_instr_done), .instr_cnt(b_cnt)
  );

  assign act16 = {a_pc_we, a_iord, a_mem_rd, a_mem_wr, a_ir_we, a_reg_dst,
                  a_mem_to_reg, a_reg_we, a_alu_src_a, a_alu_src_b, a_alu_op,
                  a_pc_src, a_illegal_op, a_instr_done};
  assign act4  = {b_pc_we, b_iord, b_mem_rd, b_mem_wr, b_ir_we, b_reg_dst,
                  b_mem_to_reg, b_reg_we, b_alu_src_a, b_alu_src_b, b_alu_op,
                  b_pc_src, b_illegal_op, b_instr_done};

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] cnt_m = '0;
  vec_t        vec[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected control words per instruction phase
  function automatic ctl_t f_fetch(input logic rdy);
    ctl_t c = '0;
    c.mem_rd = 1'b1; c.src_b = 2'b01; c.ir_we = rdy; c.pc_we = rdy;
    return c;
  endfunction
  function automatic ctl_t f_decode(input logic bad);
    ctl_t c = '0;
    c.src_b = 2'b11; c.illegal = bad;
    return c;
  endfunction
  function automatic ctl_t f_addr();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.src_b = 2'b10;
    return c;
  endfunction

  task automatic push(input logic mr, input logic z, input logic [5:0] op, input ctl_t c);
    vec.push_back('{mr, z, op, c, cnt_m});
    if (c.done) cnt_m++;
  endtask

  task automatic gen_instr(input logic [5:0] op, input logic z, input int sf, input int sm);
    ctl_t c;
    logic legal;
    legal = (op == T_R) || (op == T_LW) || (op == T_SW) || (op == T_BEQ) ||
            (op == T_ADDI) || (op == T_J);
    for (int i = 0; i < sf; i++) push(1'b0, rb(), op, f_fetch(1'b0));
    push(1'b1, rb(), op, f_fetch(1'b1));
    push(rb(), rb(), op, f_decode(!legal));
    if (!legal) return;
    case (op)
      T_R: begin
        c = '0; c.alu_src_a = 1'b1; c.aop = 2'b10; push(rb(), rb(), op, c);
        c = '0; c.reg_we = 1'b1; c.reg_dst = 1'b1; c.done = 1'b1; push(rb(), rb(), op, c);
      end
      T_LW: begin
        push(rb(), rb(), op, f_addr());
        c = '0; c.mem_rd = 1'b1; c.iord = 1'b1;
        for (int i = 0; i < sm; i++) push(1'b0, rb(), op, c);
        push(1'b1, rb(), op, c);
        c = '0; c.reg_we = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1; push(rb(), rb(), op, c);
      end
      T_SW: begin
        push(rb(), rb(), op, f_addr());
        c = '0; c.mem_wr = 1'b1; c.iord = 1'b1;
        for (int i = 0; i < sm; i++) push(1'b0, rb(), op, c);
        c.done = 1'b1; push(1'b1, rb(), op, c);
      end
      T_BEQ: begin
        c = '0; c.alu_src_a = 1'b1; c.aop = 2'b01; c.psrc = 2'b01; c.pc_we = z; c.done = 1'b1;
        push(rb(), z, op, c);
      end
      T_ADDI: begin
        push(rb(), rb(), op, f_addr());
        c = '0; c.reg_we = 1'b1; c.done = 1'b1; push(rb(), rb(), op, c);
      end
      default: begin
        c = '0; c.psrc = 2'b10; c.pc_we = 1'b1; c.done = 1'b1; push(rb(), rb(), op, c);
      end
    endcase
  endtask

  task automatic run_vec();
    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk);
      mem_ready = vec[i].mr;
      zero      = vec[i].z;
      op_c      = vec[i].op;
      #2;
      check("ctl16", 32'(act16), 32'(vec[i].exp));
      check("ctl4", 32'(act4), 32'(vec[i].exp));
      check("cnt16", 32'(a_cnt), 32'(vec[i].cnt));
      check("cnt4", 32'(b_cnt), 32'(vec[i].cnt[3:0]));
    end
    vec.delete();
  endtask

  initial begin
    logic [5:0] ops[7];
    ops = '{T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_J, T_BAD};
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; op_c = T_J;
    repeat (2) @(negedge clk);
    #2;
    check("reset_ctl", 32'(act16), 32'(f_fetch(1'b0)));
    check("reset_cnt", 32'(a_cnt), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    gen_instr(T_LW, 1'b0, 0, 0);
    gen_instr(T_SW, 1'b0, 0, 3);
    gen_instr(T_BEQ, 1'b1, 0, 0);
    gen_instr(T_BEQ, 1'b0, 0, 0);
    gen_instr(T_BAD, 1'b0, 0, 0);
    for (int k = 0; k < 16; k++) gen_instr(T_J, 1'b0, 0, 0);
    gen_instr(T_R, 1'b0, 2, 0);
    gen_instr(T_ADDI, 1'b0, 1, 0);
    gen_instr(T_LW, 1'b0, 2, 3);
    run_vec();

    for (int k = 0; k < 60; k++)
      gen_instr(ops[$urandom_range(0, 6)], rb(), $urandom_range(0, 3), $urandom_range(0, 3));
    run_vec();

    // Reset asserted in the completing cycle of a store
    push(1'b1, 1'b0, T_SW, f_fetch(1'b1));
    push(1'b1, 1'b0, T_SW, f_decode(1'b0));
    push(1'b1, 1'b0, T_SW, f_addr());
    run_vec();
    @(negedge clk);
    mem_ready = 1'b1; op_c = T_SW;
    #2;
    check("memwr_before_rst", 32'(a_mem_wr), 32'd1);
    check("done_before_rst", 32'(a_instr_done), 32'd1);
    rst_n = 1'b0;
    #1;
    check("memwr_in_rst", 32'(a_mem_wr), 32'd0);
    check("done_in_rst", 32'(a_instr_done), 32'd0);
    check("memrd_in_rst", 32'(a_mem_rd), 32'd1);
    check("ctl_in_rst", 32'(act16), 32'(f_fetch(1'b0)));
    check("cnt16_in_rst", 32'(a_cnt), 32'd0);
    check("cnt4_in_rst", 32'(b_cnt), 32'd0);
    cnt_m = '0;
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #2;
    check("fetch_after_rst", 32'(act16), 32'(f_fetch(1'b0)));
    gen_instr(T_J, 1'b0, 0, 0);
    gen_instr(T_ADDI, 1'b0, 0, 0);
    run_vec();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle control sequencer for the MIPS core. It replaces single-cycle decoding with a Moore state machine that steps a shared-memory datapath (one ALU, one memory port, instruction register) through fetch, decode, execute, memory and writeback. It supports the core opcode set: R-type, LW, SW, BEQ, ADDI and J. It sits between the instruction register opcode field and the datapath mux/enable inputs, and inserts wait states on a memory ready handshake.

## Interface

Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_c  in  6  opcode field from the instruction register
- zero  in  1  ALU zero flag, for BEQ
- mem_ready  in  1  memory has completed the current read/write
- pc_we  out  1  PC write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALU-out register
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- ir_we  out  1  instruction register write enable
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback source: 0 = ALU-out, 1 = memory data register
- reg_we  out  1  register file write enable
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B input: 00 = register B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct
- pc_src  out  2  00 = ALU result, 01 = ALU-out register, 10 = jump target
- illegal_op  out  1  one-cycle pulse when an unknown opcode is decoded
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- instr_cnt  out  CNT_W  count of retired instructions

## Operation

- State register is 4 bits. State transitions:
  - FETCH: waits while mem_ready = 0, then goes to DECODE.
  - DECODE: on RTYPE goes to EXEC; on LW or SW goes to MEMADR; on BEQ goes to BRANCH; on ADDI goes to ADDIEX; on J goes to JUMP; on any other opcode goes to FETCH.
  - MEMADR: goes to MEMRD for LW, or MEMWR for SW. The opcode is re-sampled from op_c, which the IR holds stable.
  - MEMRD: waits for mem_ready = 1, then goes to MEMWB.
  - MEMWR: waits for mem_ready = 1, then goes to FETCH.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP all go to FETCH.
  - EXEC goes to ALUWB. ADDIEX goes to ADDIWB.
- Outputs by state (every output not listed is 0):
  - FETCH: mem_rd = 1, alu_src_b = 01, pc_src = 00; ir_we = pc_we = mem_ready.
  - DECODE: alu_src_b = 11, which precomputes the branch target.
  - MEMADR and ADDIEX: alu_src_a = 1, alu_src_b = 10.
  - MEMRD: mem_rd = 1, iord = 1.
  - MEMWR: mem_wr = 1, iord = 1.
  - MEMWB: reg_we = 1, mem_to_reg = 1.
  - EXEC: alu_src_a = 1, alu_op = 10.
  - ALUWB: reg_we = 1, reg_dst = 1.
  - ADDIWB: reg_we = 1.
  - BRANCH: alu_src_a = 1, alu_op = 01, pc_src = 01, pc_we = zero.
  - JUMP: pc_src = 10, pc_we = 1.
- instr_done is 1 in MEMWB, ALUWB, ADDIWB, BRANCH and JUMP, and in MEMWR when mem_ready = 1. instr_cnt increments on each instr_done and wraps modulo 2^CNT_W.
- illegal_op is 1 in DECODE when the opcode is not one of the six supported. An illegal op does not assert instr_done and does not increment instr_cnt.

## Timing

- Reset (rst_n low) asynchronously sets state = FETCH and instr_cnt = 0.
- While rst_n is low:
  - pc_we, ir_we, reg_we, mem_wr, instr_done and illegal_op are forced to 0 combinationally.
  - mem_rd = 1, alu_src_b = 01, and every other output is 0.
- Reset asserted mid-instruction abandons the instruction. No write strobe may glitch high.
- With mem_ready held at 1, instruction latencies in cycles are: R-type 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3, illegal 2.
- Each cycle with mem_ready = 0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs are held constant during these stalls.
- Outputs are combinational from the state register, plus mem_ready and zero where listed above. There is no registered output latency.
- mem_ready sampled outside FETCH, MEMRD and MEMWR is ignored.

## Structure

- Shared package mips_mc_pkg holds:
  - state encoding constants: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11
  - opcode constants, shared with the single-cycle decoder
  - alu_src_b, alu_op and pc_src encodings
- One sub-module, mips_mc_outdec: combinational state-to-control-word decoder. The top level holds the state register, next-state logic, strobe gating and counter.
- Encodings 12–15 are unreachable. If they are ever entered, the next state is FETCH and all outputs are 0.

## Test plan

- Reset mid-MEMWR with mem_ready = 1: mem_wr = 0 immediately, state = FETCH, instr_cnt = 0. After release, the first FETCH asserts mem_rd.
- LW (op_c = 100011) with mem_ready = 1: 5 cycles, state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_we = 1 and mem_to_reg = 1 in cycle 5, and instr_cnt increments by 1.
- SW with mem_ready low for 3 cycles in MEMWR: mem_wr stays 1 for 4 cycles, instr_done pulses once, and reg_we never asserts.
- BEQ twice, first with zero = 1 then with zero = 0: pc_we = 1 with pc_src = 01 in BRANCH for the first, pc_we = 0 in BRANCH for the second. Each instruction takes 3 cycles.
- op_c = 111111: illegal_op pulses in DECODE, the next state is FETCH, and instr_cnt is unchanged.
- CNT_W = 4, 16 back-to-back J instructions: pc_we = 1 with pc_src = 10 in each JUMP, and instr_cnt wraps to 0.
